// File: rtl/axo_bist_pkg.sv
// Shared definitions for the block-RAM March C- self-test initiator:
// state codes, march element type and per-element pattern/direction tables.
package axo_bist_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_WONLY = 3'd1;
    localparam state_t ST_RD    = 3'd2;
    localparam state_t ST_CMP   = 3'd3;
    localparam state_t ST_FIN   = 3'd4;

    typedef enum logic [2:0] {
        EL_M0 = 3'd0,
        EL_M1 = 3'd1,
        EL_M2 = 3'd2,
        EL_M3 = 3'd3,
        EL_M4 = 3'd4,
        EL_M5 = 3'd5
    } elem_e;

    // Tables indexed by element number; bit i describes element Mi.
    // Direction: 1 = descending addresses.
    localparam logic [5:0] ELEM_DOWN = 6'b111000;
    // Expected read pattern (0 = all zeros, 1 = all ones); M0 never reads.
    localparam logic [5:0] ELEM_EXP  = 6'b010100;
    // Write pattern; M5 never writes.
    localparam logic [5:0] ELEM_WR   = 6'b001010;

    function automatic elem_e next_elem(input elem_e e);
        return elem_e'(e + 3'd1);
    endfunction

endpackage

// File: rtl/bram_march_tester.sv
// March C- BIST initiator for a single-port block RAM with registered read data.
// Reports pass/fail plus the element, address and data of the first mismatch.
module bram_march_tester
    import axo_bist_pkg::*;
#(
    parameter int abits  = 8,
    parameter int dbytes = 4,
    parameter int blen   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [2:0]               fail_phase,
    output logic [abits-1:0]         fail_addr,
    output logic [dbytes*blen-1:0]   fail_data,
    output logic [dbytes-1:0]        ram_we,
    output logic [abits-1:0]         ram_addr,
    output logic [dbytes*blen-1:0]   ram_wdata,
    input  logic [dbytes*blen-1:0]   ram_rdata
);

    localparam int dbits = dbytes * blen;
    localparam logic [abits-1:0] ADDR_ONE = 1;

    state_t           state;
    elem_e            elem;
    logic [abits-1:0] addr;
    logic             pass_r;

    logic [dbits-1:0] exp_pat;
    logic [dbits-1:0] wr_pat;
    logic             mismatch;
    logic             last_addr;

    always_comb begin
        exp_pat   = {dbits{ELEM_EXP[elem]}};
        wr_pat    = {dbits{ELEM_WR[elem]}};
        mismatch  = (state == ST_CMP) && (ram_rdata != exp_pat);
        last_addr = ELEM_DOWN[elem] ? (addr == '0) : (addr == '1);
    end

    // Write enable is decoded from the registered state so an asynchronous
    // reset removes it immediately; a mismatch suppresses the CMP write.
    always_comb begin
        ram_we    = '0;
        ram_wdata = '0;
        if (state == ST_WONLY) begin
            ram_we    = '1;
            ram_wdata = wr_pat;
        end else if (state == ST_CMP && elem != EL_M5 && !mismatch) begin
            ram_we    = '1;
            ram_wdata = wr_pat;
        end
    end

    always_comb begin
        ram_addr = addr;
        busy     = (state == ST_WONLY) || (state == ST_RD) || (state == ST_CMP);
        done     = (state == ST_FIN);
        pass     = pass_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            elem       <= EL_M0;
            addr       <= '0;
            pass_r     <= 1'b0;
            fail_phase <= '0;
            fail_addr  <= '0;
            fail_data  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_FIN: begin
                    if (start) begin
                        state      <= ST_WONLY;
                        elem       <= EL_M0;
                        addr       <= '0;
                        pass_r     <= 1'b0;
                        fail_phase <= '0;
                        fail_addr  <= '0;
                        fail_data  <= '0;
                    end
                end
                ST_WONLY: begin
                    if (last_addr) begin
                        state <= ST_RD;
                        elem  <= EL_M1;
                        addr  <= '0;
                    end else begin
                        addr <= addr + ADDR_ONE;
                    end
                end
                ST_RD: begin
                    state <= ST_CMP;
                end
                ST_CMP: begin
                    if (mismatch) begin
                        state      <= ST_FIN;
                        pass_r     <= 1'b0;
                        fail_phase <= elem;
                        fail_addr  <= addr;
                        fail_data  <= ram_rdata;
                    end else if (!last_addr) begin
                        state <= ST_RD;
                        addr  <= ELEM_DOWN[elem] ? (addr - ADDR_ONE) : (addr + ADDR_ONE);
                    end else if (elem == EL_M5) begin
                        state  <= ST_FIN;
                        pass_r <= 1'b1;
                    end else begin
                        state <= ST_RD;
                        elem  <= next_elem(elem);
                        addr  <= ELEM_DOWN[next_elem(elem)] ? '1 : '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_march_tester.sv
// Scoreboard bench: a 4-word x 32-bit RAM with read-side stuck-at fault injection
// beside the tester; expected run outcomes come from an array-based March C- model.
module tb_bram_march_tester;

    localparam int AB = 2;
    localparam int NW = 1 << AB;
    localparam int DB = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy, done, pass;
    logic [2:0]    fail_phase;
    logic [AB-1:0] fail_addr;
    logic [DB-1:0] fail_data;
    logic [3:0]    ram_we;
    logic [AB-1:0] ram_addr;
    logic [DB-1:0] ram_wdata;
    logic [DB-1:0] ram_rdata;

    bram_march_tester #(.abits(AB), .dbytes(4), .blen(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .pass(pass),
        .fail_phase(fail_phase), .fail_addr(fail_addr), .fail_data(fail_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM with registered read; the fault forces one bit of one address on read.
    logic [DB-1:0] mem [NW];
    bit            f_en;
    int            f_addr, f_bit;
    bit            f_val;

    function automatic logic [DB-1:0] faulty(input int a, input logic [DB-1:0] d);
        logic [DB-1:0] r;
        r = d;
        if (f_en && a == f_addr) r[f_bit] = f_val;
        return r;
    endfunction

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
        ram_rdata <= faulty(int'(ram_addr), mem[ram_addr]);
    end

    typedef struct {
        int            s;
        int            done_cyc;
        bit            pass;
        int            phase;
        int            addr;
        logic [DB-1:0] data;
        int            writes;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // March C- over a plain array: element e visits addresses in order, reads
    // (through the fault), compares, then writes; cycle numbers from phase lengths.
    function automatic exp_t model(input bit fen, input int fa, input int fb, input bit fv);
        exp_t          r;
        logic [DB-1:0] m [NW];
        logic [DB-1:0] rd, expd;
        int            a;
        r.s = 0; r.pass = 1'b1; r.phase = 0; r.addr = 0; r.data = '0;
        r.writes = 0; r.done_cyc = 11 * NW + 1;
        for (int i = 0; i < NW; i++) begin
            m[i] = '0;
            r.writes++;
        end
        for (int e = 1; e <= 5; e++) begin
            for (int k = 0; k < NW; k++) begin
                a  = (e >= 3) ? NW - 1 - k : k;
                rd = m[a];
                if (fen && a == fa) rd[fb] = fv;
                expd = (e == 2 || e == 4) ? '1 : '0;
                if (rd != expd) begin
                    r.pass     = 1'b0;
                    r.phase    = e;
                    r.addr     = a;
                    r.data     = rd;
                    r.done_cyc = NW + 1 + (e - 1) * 2 * NW + 2 * k + 1 + 1;
                    return r;
                end
                if (e < 5) begin
                    m[a] = (e % 2 == 1) ? '1 : '0;
                    r.writes++;
                end
            end
        end
        return r;
    endfunction

    // Monitor: tracks run start and write cycles, compares on each rising done.
    bit   prev_busy = 1'b0, prev_done = 1'b0;
    int   busy_start = 0, run_writes = 0, idle_writes = 0;
    exp_t ge;

    always @(negedge clk) begin
        if (!busy && ram_we != '0) idle_writes++;
        if (busy && !prev_busy) begin
            busy_start = cyc;
            run_writes = 0;
        end
        if (busy && ram_we != '0) run_writes++;
        if (done && !prev_done) begin
            if (sb.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_done: got done at cycle %0d expected no run", cyc);
            end else begin
                ge = sb.pop_front();
                chk("done_cycle",  cyc - ge.s,       ge.done_cyc);
                chk("busy_start",  busy_start - ge.s, 1);
                chk("busy_at_done", busy,             0);
                chk("pass",        pass,             ge.pass);
                chk("fail_phase",  fail_phase,       ge.phase);
                chk("fail_addr",   fail_addr,        ge.addr);
                chk("fail_data",   fail_data,        ge.data);
                chk("write_cycles", run_writes,      ge.writes);
            end
        end
        prev_busy = busy;
        prev_done = done;
    end

    task automatic do_start(output int s);
        @(negedge clk);
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_cycle1();
        chk("c1_busy",  busy, 1);
        chk("c1_done",  done, 0);
        chk("c1_pass",  pass, 0);
        chk("c1_phase", fail_phase, 0);
        chk("c1_faddr", fail_addr, 0);
        chk("c1_fdata", fail_data, 0);
        chk("c1_we",    ram_we, 4'hF);
        chk("c1_addr",  ram_addr, 0);
        chk("c1_wdata", ram_wdata, 0);
    endtask

    task automatic wait_done(input bit noise);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) ok = 1'b1;
            else if (noise && busy && $urandom_range(0, 3) == 0) start = 1'b1;
        end
        start = 1'b0;
        if (!ok) begin
            tests++; fails++;
            $display("FAIL timeout: got no done within 200 cycles expected done");
            sb.delete();
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
        end
    endtask

    task automatic run(input bit fen, input int fa, input int fb, input bit fv, input bit noise);
        exp_t e;
        int   s;
        f_en = fen; f_addr = fa; f_bit = fb; f_val = fv;
        do_start(s);
        e   = model(fen, fa, fb, fv);
        e.s = s;
        sb.push_back(e);
        check_cycle1();
        wait_done(noise);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_pass"},  pass, 0);
        chk({tag, "_phase"}, fail_phase, 0);
        chk({tag, "_faddr"}, fail_addr, 0);
        chk({tag, "_fdata"}, fail_data, 0);
        chk({tag, "_we"},    ram_we, 0);
        chk({tag, "_addr"},  ram_addr, 0);
        chk({tag, "_wdata"}, ram_wdata, 0);
    endtask

    initial begin
        int s;
        exp_t e;
        rst_n = 1'b0;
        start = 1'b0;
        f_en  = 1'b0; f_addr = 0; f_bit = 0; f_val = 1'b0;
        for (int i = 0; i < NW; i++) mem[i] = $urandom;

        repeat (2) @(negedge clk);
        check_all_zero("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("idle_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_we", ram_we, 0);
        end

        run(1'b0, 0, 0, 1'b0, 1'b0);          // clean
        run(1'b1, 2, 3, 1'b1, 1'b0);          // SA1 bit 3 @ addr 2 -> M1
        run(1'b1, 3, 0, 1'b0, 1'b1);          // SA0 bit 0 @ addr 3 -> M2, start noise
        run(1'b0, 0, 0, 1'b0, 1'b1);          // rerun from FIN, clean, start noise

        // Abort a clean run with reset in cycle 20.
        f_en = 1'b0;
        do_start(s);
        e   = model(1'b0, 0, 0, 1'b0);
        e.s = s;
        sb.push_back(e);
        while (cyc < s + 20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("abort");
        void'(sb.pop_back());
        repeat (3) begin
            @(negedge clk);
            chk("abort_we", ram_we, 0);
        end
        rst_n = 1'b1;
        run(1'b0, 0, 0, 1'b0, 1'b0);

        for (int t = 0; t < 12; t++)
            run($urandom_range(0, 3) != 0, $urandom_range(0, NW - 1),
                $urandom_range(0, DB - 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        repeat (2) @(negedge clk);
        chk("idle_writes", idle_writes, 0);
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
